// File: rtl/palindrome_gen_if.sv
// palindrome_gen_if: word-in / serial-bit-out handshake bundle for palindrome_gen.
// master = word producer and bit consumer, slave = the generator itself.
interface palindrome_gen_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] data_i;
   logic             mode_i;
   logic             valid_i;
   logic             ready_o;
   logic             x_o;
   logic             x_valid_o;
   logic             last_o;

   modport master (
      output data_i, mode_i, valid_i,
      input  ready_o, x_o, x_valid_o, last_o
   );

   modport slave (
      input  data_i, mode_i, valid_i,
      output ready_o, x_o, x_valid_o, last_o
   );
endinterface

// File: rtl/palindrome_gen.sv
// palindrome_gen: serial palindrome frame generator.
// A WIDTH-bit word is sent MSB first, then mirrored back. The mirror starts
// at d[0] for even frames and at d[1] for odd frames. Odd frames send the
// centre bit d[0] only once.
// Optional feature macro: PALGEN_GAP_EN. When it is defined, a one-cycle GAP
// state follows every frame and back-to-back frames are not possible.
// state_q/idx_q always describe the bit currently presented on x_o.
module palindrome_gen #(
   parameter int WIDTH = 4
) (
   input logic             clk,
   input logic             reset,
   palindrome_gen_if.slave bus
);

   localparam int                IDX_W    = $clog2(WIDTH) + 1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

`ifdef PALGEN_GAP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, REV = 2'd2, GAP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, REV = 2'd2} state_t;
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             mode_q, mode_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             last_q, last_d;
   logic             ready;
   logic             accept;

   // Select word bit 'i'; the loop keeps the index width independent of WIDTH.
   function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [IDX_W-1:0] i);
      logic b;
      b = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         if (i == IDX_W'(k)) b = w[k];
      end
      return b;
   endfunction

   // Ready in IDLE, and on the final bit when frames may run back-to-back.
   always_comb begin
      ready = 1'b0;
      if (!reset) begin
         if (state_q == IDLE) begin
            ready = 1'b1;
         end
`ifndef PALGEN_GAP_EN
         else if ((state_q == REV) && (idx_q == IDX_LAST)) begin
            ready = 1'b1;
         end
`endif
      end
   end

   assign accept = bus.valid_i && ready;

   // Next state, bit index and the registered value of the next output bit.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      word_d    = word_q;
      mode_d    = mode_q;
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      last_d    = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         FWD: begin
            if (idx_q == '0) begin
               state_d = REV;
               idx_d   = mode_q ? IDX_ONE : '0;
            end else begin
               idx_d = idx_q - IDX_ONE;
            end
            x_d       = bit_at(word_q, idx_d);
            x_valid_d = 1'b1;
            last_d    = (state_d == REV) && (idx_d == IDX_LAST);
         end
         REV: begin
            if (idx_q == IDX_LAST) begin
`ifdef PALGEN_GAP_EN
               state_d = GAP;
`else
               state_d = IDLE;
`endif
            end else begin
               idx_d     = idx_q + IDX_ONE;
               x_d       = bit_at(word_q, idx_d);
               x_valid_d = 1'b1;
               last_d    = (idx_d == IDX_LAST);
            end
         end
`ifdef PALGEN_GAP_EN
         GAP: begin
            state_d = IDLE;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // An accept (IDLE, or the last REV bit) starts a new frame with its MSB.
      if (accept) begin
         state_d   = FWD;
         idx_d     = IDX_LAST;
         word_d    = bus.data_i;
         mode_d    = bus.mode_i;
         x_d       = bus.data_i[WIDTH-1];
         x_valid_d = 1'b1;
         last_d    = 1'b0;
      end
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         word_q    <= '0;
         mode_q    <= 1'b0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         mode_q    <= mode_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         last_q    <= last_d;
      end
   end

   assign bus.ready_o   = ready;
   assign bus.x_o       = x_q;
   assign bus.x_valid_o = x_valid_q;
   assign bus.last_o    = last_q;

endmodule
